// File: rtl/seven_seg_scanner.sv
// Multiplexed N-digit 7-segment scanner with per-digit decimal point,
// per-digit blanking and a guarded brightness PWM inside each digit slot.
// Each slot starts with GUARD_TICKS dark clocks so the previous digit's
// anode has fully released before the next pattern is shown (anti-ghosting).
// The slot is followed by up to (2**BRIGHT_W-1) brightness steps of
// STEP_TICKS clocks each.
module seven_seg_scanner #(
  parameter int NUM_DIGITS       = 4,
  parameter int GUARD_TICKS      = 2000,
  parameter int STEP_TICKS       = 1750,
  parameter int BRIGHT_W         = 4,
  parameter int ANODE_ACTIVE_LOW = 1,
  parameter int SEG_ACTIVE_LOW   = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [7*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic [BRIGHT_W-1:0]     brightness,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0] digit_sel,
  output logic                    frame_tick
);

  localparam int SLOT_TICKS = GUARD_TICKS + ((2**BRIGHT_W) - 1) * STEP_TICKS;
  localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  // One spare bit so the lit-window product never wraps at full brightness.
  localparam int CW         = $clog2(SLOT_TICKS) + 1;

  localparam logic ANODE_INV = (ANODE_ACTIVE_LOW != 0);
  localparam logic SEG_INV   = (SEG_ACTIVE_LOW != 0);

  localparam logic [CW-1:0]    SLOT_LAST = CW'(SLOT_TICKS - 1);
  localparam logic [CW-1:0]    GUARD_C   = CW'(GUARD_TICKS);
  localparam logic [CW-1:0]    STEP_C    = CW'(STEP_TICKS);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  // Scan position.
  logic [CW-1:0]           slot_cnt_q,  slot_cnt_d;
  logic [IDX_W-1:0]        digit_idx_q, digit_idx_d;

  // Per-slot shadow copies of the inputs, latched at slot start so that the
  // datapath can rewrite its registers at any time without tearing a digit.
  logic [6:0]              pat_sh_q,    pat_sh_d;
  logic                    dp_sh_q,     dp_sh_d;
  logic                    blank_sh_q,  blank_sh_d;
  logic [BRIGHT_W-1:0]     bright_sh_q, bright_sh_d;

  // Registered outputs, held internally as active-high "on" bits.
  logic [NUM_DIGITS-1:0]   anode_on_q,  anode_on_d;
  logic [6:0]              seg_on_q,    seg_on_d;
  logic                    dp_on_q,     dp_on_d;
  logic [IDX_W-1:0]        sel_q,       sel_d;
  logic                    frame_q,     frame_d;

  // Helper values for the current slot.
  logic [CW-1:0]           on_ticks;
  logic                    in_window;
  logic                    lit;
  logic [6:0]              cur_pat;
  logic                    cur_dp;
  logic                    cur_blank;

  // Number of lit clocks after the guard for the captured brightness.
  assign on_ticks = CW'(bright_sh_q) * STEP_C;

  // Lit window: past the guard and still inside the brightness on-time.
  assign in_window = (slot_cnt_q >= GUARD_C) &&
                     ((slot_cnt_q - GUARD_C) < on_ticks);
  assign lit       = in_window && !blank_sh_q;

  // Select the live inputs of the digit whose slot is starting.
  always_comb begin
    cur_pat   = 7'd0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digit_idx_q == IDX_W'(i)) begin
        cur_pat   = digits[7*i +: 7];
        cur_dp    = dp_in[i];
        cur_blank = blank_mask[i];
      end
    end
  end

  // Next-state: scan counters, shadow capture and the registered outputs.
  always_comb begin
    slot_cnt_d  = '0;
    digit_idx_d = '0;
    pat_sh_d    = pat_sh_q;
    dp_sh_d     = dp_sh_q;
    blank_sh_d  = blank_sh_q;
    bright_sh_d = bright_sh_q;
    anode_on_d  = '0;
    seg_on_d    = 7'd0;
    dp_on_d     = 1'b0;
    sel_d       = '0;
    frame_d     = 1'b0;

    if (en) begin
      if (slot_cnt_q == SLOT_LAST) begin
        slot_cnt_d  = '0;
        digit_idx_d = (digit_idx_q == IDX_LAST) ? '0 : digit_idx_q + IDX_W'(1);
      end else begin
        slot_cnt_d  = slot_cnt_q + CW'(1);
        digit_idx_d = digit_idx_q;
      end

      if (slot_cnt_q == '0) begin
        pat_sh_d    = cur_pat;
        dp_sh_d     = cur_dp;
        blank_sh_d  = cur_blank;
        bright_sh_d = brightness;
      end

      // Slot position 0 is always inside the guard, so the previous slot's
      // shadow values are never shown here.
      if (lit) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          anode_on_d[i] = (digit_idx_q == IDX_W'(i));
        end
        seg_on_d = pat_sh_q;
        dp_on_d  = dp_sh_q;
      end

      sel_d   = digit_idx_q;
      frame_d = (slot_cnt_q == '0) && (digit_idx_q == '0);
    end
  end

  // State and output registers; reset darkens the display immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt_q  <= '0;
      digit_idx_q <= '0;
      pat_sh_q    <= 7'd0;
      dp_sh_q     <= 1'b0;
      blank_sh_q  <= 1'b0;
      bright_sh_q <= '0;
      anode_on_q  <= '0;
      seg_on_q    <= 7'd0;
      dp_on_q     <= 1'b0;
      sel_q       <= '0;
      frame_q     <= 1'b0;
    end else begin
      slot_cnt_q  <= slot_cnt_d;
      digit_idx_q <= digit_idx_d;
      pat_sh_q    <= pat_sh_d;
      dp_sh_q     <= dp_sh_d;
      blank_sh_q  <= blank_sh_d;
      bright_sh_q <= bright_sh_d;
      anode_on_q  <= anode_on_d;
      seg_on_q    <= seg_on_d;
      dp_on_q     <= dp_on_d;
      sel_q       <= sel_d;
      frame_q     <= frame_d;
    end
  end

  // Board polarity is a constant inversion of the registered on-bits.
  assign anode      = anode_on_q ^ {NUM_DIGITS{ANODE_INV}};
  assign seg        = seg_on_q ^ {7{SEG_INV}};
  assign dp         = dp_on_q ^ SEG_INV;
  assign digit_sel  = sel_q;
  assign frame_tick = frame_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner: a 4-digit instance checked every cycle
// against a scoreboard fed by an edge-count model, plus a 1-digit instance
// with inverted polarities checked at directed points.
module tb_seven_seg_scanner;

  localparam int N    = 4;
  localparam int SLOT = 11;  // 2 + 3*3

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        en    = 1'b0;
  logic [27:0] digits;
  logic [3:0]  dp_in;
  logic [3:0]  blank_mask;
  logic [1:0]  brightness;
  logic [3:0]  anode;
  logic [6:0]  seg;
  logic        dp;
  logic [1:0]  digit_sel;
  logic        frame_tick;

  logic [6:0]  p_digits;
  logic        p_dp_in;
  logic        p_blank;
  logic [1:0]  p_bright;
  logic        p_anode;
  logic [6:0]  p_seg;
  logic        p_dp;
  logic        p_sel;
  logic        p_ft;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] sg;
    logic       dp;
    logic [1:0] sel;
    logic       ft;
  } exp_t;

  exp_t q[$];

  seven_seg_scanner #(
    .NUM_DIGITS(4), .GUARD_TICKS(2), .STEP_TICKS(3), .BRIGHT_W(2),
    .ANODE_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(0)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .digits(digits), .dp_in(dp_in),
    .blank_mask(blank_mask), .brightness(brightness), .anode(anode),
    .seg(seg), .dp(dp), .digit_sel(digit_sel), .frame_tick(frame_tick)
  );

  seven_seg_scanner #(
    .NUM_DIGITS(1), .GUARD_TICKS(2), .STEP_TICKS(3), .BRIGHT_W(2),
    .ANODE_ACTIVE_LOW(0), .SEG_ACTIVE_LOW(1)
  ) u_pol (
    .clk(clk), .rst_n(rst_n), .en(en), .digits(p_digits), .dp_in(p_dp_in),
    .blank_mask(p_blank), .brightness(p_bright), .anode(p_anode),
    .seg(p_seg), .dp(p_dp), .digit_sel(p_sel), .frame_tick(p_ft)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference model: position in the scan is derived from the number of
  // enabled edges since the display was (re)started.
  int         kk;
  int         mc;
  int         md;
  logic       m_lit;
  logic [6:0] m_pat;
  logic       m_dp;
  logic       m_blank;
  logic [1:0] m_bright;
  exp_t       m_e;

  always @(posedge clk) begin
    if (!rst_n || !en) begin
      m_e.an  = 4'hF;
      m_e.sg  = 7'h00;
      m_e.dp  = 1'b0;
      m_e.sel = 2'd0;
      m_e.ft  = 1'b0;
      kk      = 0;
    end else begin
      mc = kk % SLOT;
      md = (kk / SLOT) % N;
      if (mc == 0) begin
        m_pat    = digits[7*md +: 7];
        m_dp     = dp_in[md];
        m_blank  = blank_mask[md];
        m_bright = brightness;
      end
      m_lit   = !m_blank && (mc >= 2) && ((mc - 2) < int'(m_bright) * 3);
      m_e.an  = m_lit ? ~(4'b0001 << md) : 4'hF;
      m_e.sg  = m_lit ? m_pat : 7'h00;
      m_e.dp  = m_lit & m_dp;
      m_e.sel = 2'(md);
      m_e.ft  = (kk % (N * SLOT)) == 0;
      kk++;
    end
    q.push_back(m_e);
  end

  // Scoreboard: compare each cycle's outputs away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("scan", {17'd0, anode, seg, dp, digit_sel, frame_tick}, {17'd0, e});
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    digits     = {7'h4F, 7'h5B, 7'h06, 7'h3F};
    dp_in      = 4'b0010;
    blank_mask = 4'b0000;
    brightness = 2'd3;
    p_digits   = 7'h5B;
    p_dp_in    = 1'b1;
    p_blank    = 1'b0;
    p_bright   = 2'd3;

    // Reset state before any clock edge.
    #2;
    chk("rst_anode", {28'd0, anode}, 32'hF);
    chk("rst_seg_dp", {24'd0, seg, dp}, 32'h0);
    chk("rst_sel_ft", {29'd0, digit_sel, frame_tick}, 32'h0);
    chk("rst_pol", {23'd0, p_anode, p_seg, p_dp}, {23'd0, 1'b0, 7'h7F, 1'b1});

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic scan with shadowing; polarity instance checked alongside.
    en = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if ((k % SLOT) >= 2)
        chk("pol_lit", {22'd0, p_anode, p_seg, p_dp, p_sel, p_ft},
            {22'd0, 1'b1, 7'h24, 1'b0, 1'b0, 1'b0});
      else
        chk("pol_idle", {22'd0, p_anode, p_seg, p_dp, p_sel, p_ft},
            {22'd0, 1'b0, 7'h7F, 1'b1, 1'b0, (k % SLOT) == 0});
      if (k == 4)  digits[6:0] = 7'h7F;
      if (k == 10) chk("shadow_hold", {25'd0, seg}, 32'h3F);
      if (k == 46) chk("shadow_new", {25'd0, seg}, 32'h7F);
    end

    // PWM levels.
    brightness = 2'd1;
    repeat (50) @(negedge clk);
    brightness = 2'd0;
    repeat (100) @(negedge clk);

    // Blanking of digit 2.
    brightness = 2'd3;
    blank_mask = 4'b0100;
    repeat (50) @(negedge clk);
    blank_mask = 4'b0000;

    // Enable drop mid-slot, then restart from digit 0.
    en = 1'b0;
    repeat (3) @(negedge clk);
    en = 1'b1;
    repeat (15) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    chk("en_drop", {28'd0, anode}, 32'hF);
    repeat (2) @(negedge clk);
    en = 1'b1;
    repeat (5) @(negedge clk);
    chk("pre_reset", {28'd0, anode}, 32'hE);

    // Asynchronous reset between edges.
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_anode", {28'd0, anode}, 32'hF);
    chk("async_seg", {24'd0, seg, dp}, 32'h0);
    chk("async_pol", {23'd0, p_anode, p_seg, p_dp}, {23'd0, 1'b0, 7'h7F, 1'b1});
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/seven_seg_scanner.md
Name: seven_seg_scanner

Overview:
- Parametrised multiplexed 7-segment display driver. Generalises the fixed 4-digit scanner to N digits.
- Adds per-digit decimal point and per-digit blanking.
- Adds a brightness PWM with an anti-ghosting guard interval and selectable output polarities.
- Sits between the datapath's digit-pattern registers and the board's anode/segment pins.
- Emits a frame strobe for display-synchronous updates.

Parameters:
- NUM_DIGITS, 4: number of multiplexed digits (>=1).
- GUARD_TICKS, 2000: clocks per slot with all anodes off (>=1).
- STEP_TICKS, 1750: clocks per brightness step (>=1).
- BRIGHT_W, 4: brightness input width (>=1).
- ANODE_ACTIVE_LOW, 1: 1 = anode driven 0 when selected.
- SEG_ACTIVE_LOW, 0: 0 = seg/dp bits passed as given; 1 = inverted at output.

Derived values:
- SLOT_TICKS = GUARD_TICKS + (2**BRIGHT_W - 1)*STEP_TICKS.
- IDX_W = max(1, clog2(NUM_DIGITS)).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  scan enable
- digits  in  7*NUM_DIGITS  digit i pattern at [7i+6:7i]; bit 7i = segment a … 7i+6 = segment g; 1 = lit; digit 0 = rightmost
- dp_in  in  NUM_DIGITS  decimal point per digit, 1 = lit
- blank_mask  in  NUM_DIGITS  1 = digit i dark for its whole slot
- brightness  in  BRIGHT_W  0 = off, all-ones = max
- anode  out  NUM_DIGITS  digit select, polarity per ANODE_ACTIVE_LOW
- seg  out  7  seg[0]=a … seg[6]=g, polarity per SEG_ACTIVE_LOW
- dp  out  1  decimal point, polarity per SEG_ACTIVE_LOW
- digit_sel  out  IDX_W  index of the slot currently scanned
- frame_tick  out  1  one-cycle pulse at start of each digit-0 slot

Behaviour:
- Reset (async, rst_n=0):
  - slot_cnt=0, digit_idx=0.
  - anode all inactive; seg and dp unlit in the configured polarity.
  - digit_sel=0, frame_tick=0.
  - Shadow registers cleared.
  - Takes effect immediately regardless of clk; applies mid-slot as well.
- en=0 at an edge:
  - slot_cnt<=0, digit_idx<=0.
  - All outputs driven to their reset values.
  - Disabling mid-slot darkens the display at that edge.
  - Re-enabling always restarts at digit 0.
- en=1 at an edge; let c = slot_cnt and d = digit_idx before the edge:
  - Counter update: if c == SLOT_TICKS-1, then slot_cnt<=0 and digit_idx<=(d==NUM_DIGITS-1 ? 0 : d+1); otherwise slot_cnt<=c+1.
  - If c==0: capture pattern d, dp_in[d], blank_mask[d] and brightness into shadow registers. Inputs may change freely; they have no effect until the next slot start.
  - Registered outputs:
    - Digit d is lit iff !blank_sh and c >= GUARD_TICKS and (c - GUARD_TICKS) < bright_sh*STEP_TICKS.
    - When lit: anode has only bit d active, and seg/dp = shadow pattern.
    - When not lit: all anodes inactive and seg/dp unlit.
    - digit_sel<=d.
    - frame_tick<=(c==0 && d==0).
- Consequences of this rule:
  - Brightness 0 is dark.
  - Maximum brightness is lit for the whole slot except the guard.
  - A blanked digit still consumes its slot, so the refresh rate stays constant.
  - Never more than one anode is active.
- Comparison arithmetic: at least clog2(SLOT_TICKS)+1 bits, no overflow at the maximum brightness.
- Refresh period: NUM_DIGITS*SLOT_TICKS clocks.

Test Plan (NUM_DIGITS=4, GUARD_TICKS=2, STEP_TICKS=3, BRIGHT_W=2, so SLOT_TICKS=11; E0 = first edge with en=1):
- Basic scan: digits = d0 7'h3F, d1 7'h06, d2 7'h5B, d3 7'h4F; brightness=3; dp_in=4'b0010; blank_mask=0 ->
  - anode=4'b1110 with seg=7'h3F, dp=0 at edges E0+2..E0+10;
  - anode=1101 with seg=7'h06, dp=1 at E0+13..E0+21;
  - anode=1011 at E0+24..E0+32;
  - anode=0111 at E0+35..E0+43;
  - all anodes 1111 at E0, E0+1, E0+11, E0+12, …;
  - frame_tick=1 only at E0 and E0+44.
- PWM: brightness=1 -> digit 0 lit only at E0+2..E0+4; brightness=0 -> anode stays 4'b1111 across 100 clocks while digit_sel still cycles 0,1,2,3.
- Shadowing: change digits[6:0] to 7'h7F at E0+5 -> seg stays 7'h3F through E0+10; the new value appears at E0+46.
- Blanking: blank_mask=4'b0100 -> anode never 4'b1011; digit 3 still lit at E0+35..E0+43.
- Enable/reset mid-slot: drop en at E0+15 -> all inactive at that edge; re-raise -> digit 0 restarts with guard. Assert rst_n=0 between edges -> outputs inactive without waiting for clk.
- Polarity: ANODE_ACTIVE_LOW=0, SEG_ACTIVE_LOW=1, NUM_DIGITS=1 -> anode=1 while lit; seg=~pattern; idle seg=7'h7F, dp=1; digit_sel constantly 0.
